// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller: forward-select
// encodings, FSM state encodings, the default register address width and a
// small helper that resolves a forward source from scoreboard hits.
package pipe_hazard_ctrl_pkg;

    localparam int REG_ABUS = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_e;

    // EX wins over MEM, but a load in EX has no result yet and cannot forward.
    function automatic logic [1:0] fwd_select(input logic ex_hit,
                                              input logic ex_is_load,
                                              input logic mem_hit);
        logic [1:0] sel;
        sel = FWD_REG;
        if (mem_hit) sel = FWD_MEM;
        if (ex_hit && !ex_is_load) sel = FWD_EX;
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the ID stage and the hazard controller: decoded-instruction
// fields and memory status flow in, stall/flush/bubble controls, forward
// selects and the stall counter flow out.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_ABUS,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_wr_en;
    logic              id_is_load;
    logic              id_redirect;
    logic              dmem_busy;

    logic              stall_if;
    logic              stall_id;
    logic              stall_ex;
    logic              bubble_ex;
    logic              flush_if;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;

    // The pipeline side presents the ID instruction and consumes the controls.
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr_en, id_is_load, id_redirect, dmem_busy,
        input  stall_if, stall_id, stall_ex, bubble_ex, flush_if,
               fwd_a, fwd_b, stall_cnt
    );

    // The controller observes the ID instruction and drives the controls.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr_en, id_is_load, id_redirect, dmem_busy,
        output stall_if, stall_id, stall_ex, bubble_ex, flush_if,
               fwd_a, fwd_b, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Shadow copy of the destination registers sitting in EX and MEM, plus the
// register-match logic that yields the load-use hazard and forward selects.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_ABUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hold,
    input  logic              i_bubble,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_wr_en,
    input  logic              i_id_is_load,
    output logic              o_load_use,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b
);

    logic              r_ex_v;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_wr;
    logic              r_ex_ld;
    logic              r_mem_v;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_wr;

    logic w_ex_hit_a;
    logic w_ex_hit_b;
    logic w_mem_hit_a;
    logic w_mem_hit_b;

    // Slots freeze on hold, take a NOP into EX on bubble, otherwise shift ID->EX->MEM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex_v   <= 1'b0;
            r_ex_rd  <= '0;
            r_ex_wr  <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_mem_v  <= 1'b0;
            r_mem_rd <= '0;
            r_mem_wr <= 1'b0;
        end else if (!i_hold) begin
            r_mem_v  <= r_ex_v;
            r_mem_rd <= r_ex_rd;
            r_mem_wr <= r_ex_wr;
            if (i_bubble) begin
                r_ex_v  <= 1'b0;
                r_ex_rd <= '0;
                r_ex_wr <= 1'b0;
                r_ex_ld <= 1'b0;
            end else begin
                r_ex_v  <= i_id_valid;
                r_ex_rd <= i_id_rd;
                r_ex_wr <= i_id_wr_en;
                r_ex_ld <= i_id_is_load;
            end
        end
    end

    // A slot only matches a real, writing instruction whose rd is not x0.
    always_comb begin
        w_ex_hit_a  = r_ex_v  && r_ex_wr  && (r_ex_rd  != '0) && (r_ex_rd  == i_id_rs1);
        w_ex_hit_b  = r_ex_v  && r_ex_wr  && (r_ex_rd  != '0) && (r_ex_rd  == i_id_rs2);
        w_mem_hit_a = r_mem_v && r_mem_wr && (r_mem_rd != '0) && (r_mem_rd == i_id_rs1);
        w_mem_hit_b = r_mem_v && r_mem_wr && (r_mem_rd != '0) && (r_mem_rd == i_id_rs2);
    end

    // Hazard and forward decisions apply only when ID holds a real instruction.
    always_comb begin
        o_load_use = i_id_valid && r_ex_ld &&
                     ((i_id_use_rs1 && w_ex_hit_a) || (i_id_use_rs2 && w_ex_hit_b));
        o_fwd_a    = FWD_REG;
        o_fwd_b    = FWD_REG;
        if (i_id_valid) begin
            o_fwd_a = fwd_select(w_ex_hit_a, r_ex_ld, w_mem_hit_a);
            o_fwd_b = fwd_select(w_ex_hit_b, r_ex_ld, w_mem_hit_b);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage pipeline scheduler: load-use stalls with bubble insertion,
// redirect flushes and full freezes while data memory is busy. Controls are
// decided in the same cycle the condition appears, so they are a function of
// the registered FSM state and the current ID/memory inputs.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = REG_ABUS,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int              LAT_W    = 2;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LOAD_LAT - 1);

    state_e           r_state;
    state_e           r_saved;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    state_e     w_resume;
    state_e     w_base;
    logic       w_load_use;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_stall_if;
    logic       w_stall_id;
    logic       w_stall_ex;
    logic       w_bubble_ex;
    logic       w_flush_if;

    hazard_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .i_hold       (w_stall_ex),
        .i_bubble     (w_bubble_ex),
        .i_id_valid   (bus.id_valid),
        .i_id_rs1     (bus.id_rs1),
        .i_id_rs2     (bus.id_rs2),
        .i_id_use_rs1 (bus.id_use_rs1),
        .i_id_use_rs2 (bus.id_use_rs2),
        .i_id_rd      (bus.id_rd),
        .i_id_wr_en   (bus.id_wr_en),
        .i_id_is_load (bus.id_is_load),
        .o_load_use   (w_load_use),
        .o_fwd_a      (w_fwd_a),
        .o_fwd_b      (w_fwd_b)
    );

    // Resolve the state actually in force this cycle: leaving MEMWAIT resumes the saved state, and an exhausted LDSTALL behaves as RUN.
    always_comb begin
        w_resume = (r_state == ST_MEMWAIT) ? r_saved : r_state;
        w_base   = (w_resume == ST_LDSTALL && r_lat_cnt == '0) ? ST_RUN : w_resume;
    end

    // Same-cycle control decode with priority memory-busy > load stall > redirect.
    always_comb begin
        w_stall_if  = 1'b0;
        w_stall_id  = 1'b0;
        w_stall_ex  = 1'b0;
        w_bubble_ex = 1'b0;
        w_flush_if  = 1'b0;
        if (rst) begin
            if (bus.dmem_busy) begin
                w_stall_if = 1'b1;
                w_stall_id = 1'b1;
                w_stall_ex = 1'b1;
            end else if (w_base == ST_LDSTALL || w_load_use) begin
                w_stall_if  = 1'b1;
                w_stall_id  = 1'b1;
                w_bubble_ex = 1'b1;
            end else begin
                w_flush_if = bus.id_valid && bus.id_redirect;
            end
        end
    end

    // FSM: remember where to resume after a memory wait and count remaining load bubbles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_saved   <= ST_RUN;
            r_lat_cnt <= '0;
        end else if (bus.dmem_busy) begin
            r_state <= ST_MEMWAIT;
            r_saved <= w_base;
        end else if (w_base == ST_LDSTALL) begin
            r_state   <= ST_LDSTALL;
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
        end else if (w_load_use) begin
            r_state   <= ST_LDSTALL;
            r_lat_cnt <= LAT_INIT;
        end else begin
            r_state <= ST_RUN;
        end
    end

    // Performance counter of cycles in which the ID instruction was held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_id) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_if  = w_stall_if;
    assign bus.stall_id  = w_stall_id;
    assign bus.stall_ex  = w_stall_ex;
    assign bus.bubble_ex = w_bubble_ex;
    assign bus.flush_if  = w_flush_if;
    assign bus.fwd_a     = rst ? w_fwd_a : FWD_REG;
    assign bus.fwd_b     = rst ? w_fwd_b : FWD_REG;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed pipeline scenarios then
// randomized instruction streams, all compared against a cycle-level
// pipeline model that tracks pending load bubbles and the EX/MEM contents.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   localparam int REG_AW      = 5;
   localparam int LOAD_LAT    = 2;
   localparam int CNT_W       = 32;
   localparam int RAND_CYCLES = 3000;

   typedef struct {
      bit v;
      int rs1;
      int rs2;
      bit u1;
      bit u2;
      int rd;
      bit wr;
      bit ld;
      bit redir;
   } instr_t;

   typedef struct {
      bit v;
      int rd;
      bit wr;
      bit ld;
   } slot_t;

   logic clk;
   logic rst;

   pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

   pipe_hazard_ctrl #(
      .REG_AW   (REG_AW),
      .LOAD_LAT (LOAD_LAT),
      .CNT_W    (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   slot_t            mEx;
   slot_t            mMem;
   int               mPending;
   logic [CNT_W-1:0] mStallCnt;

   bit         eStallIf, eStallId, eStallEx, eBubble, eFlush, eHazard;
   logic [1:0] eFwdA, eFwdB;

   int checkCount = 0;
   int passCount  = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic instr_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit wr, bit ld, bit redir);
      instr_t t;
      t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
      t.rd = rd; t.wr = wr; t.ld = ld; t.redir = redir;
      return t;
   endfunction

   function automatic bit slotHits(slot_t s, int rs);
      return s.v && s.wr && (s.rd != 0) && (s.rd == rs);
   endfunction

   function automatic logic [1:0] fwdOf(instr_t ins, int rs);
      if (!ins.v) return 2'd0;
      if (slotHits(mEx, rs) && !mEx.ld) return 2'd1;
      if (slotHits(mMem, rs)) return 2'd2;
      return 2'd0;
   endfunction

   function automatic void modelReset();
      mEx       = '{0, 0, 0, 0};
      mMem      = '{0, 0, 0, 0};
      mPending  = 0;
      mStallCnt = '0;
   endfunction

   // What the pipeline should see this cycle given its contents and inputs.
   function automatic void computeExpected(bit r, instr_t ins, bit busy);
      eStallIf = 0; eStallId = 0; eStallEx = 0; eBubble = 0; eFlush = 0;
      eFwdA = 2'd0; eFwdB = 2'd0;
      eHazard = ins.v && mEx.v && mEx.ld &&
                ((ins.u1 && slotHits(mEx, ins.rs1)) || (ins.u2 && slotHits(mEx, ins.rs2)));
      if (!r) return;
      eFwdA = fwdOf(ins, ins.rs1);
      eFwdB = fwdOf(ins, ins.rs2);
      if (busy) begin
         eStallIf = 1; eStallId = 1; eStallEx = 1;
      end else if (mPending > 0 || eHazard) begin
         eStallIf = 1; eStallId = 1; eBubble = 1;
      end else begin
         eFlush = ins.v && ins.redir;
      end
   endfunction

   // Advance the pipeline contents across one clock edge.
   function automatic void modelStep(bit r, instr_t ins, bit busy);
      if (!r) begin
         modelReset();
         return;
      end
      if (eStallId) mStallCnt = mStallCnt + 1;
      if (busy) return;
      mMem = mEx;
      if (mPending > 0) begin
         mEx = '{0, 0, 0, 0};
         mPending--;
      end else if (eHazard) begin
         mEx = '{0, 0, 0, 0};
         mPending = LOAD_LAT - 1;
      end else begin
         mEx = '{ins.v, ins.rd, ins.wr, ins.ld};
      end
   endfunction

   task automatic applyStimulus(input bit r, input instr_t ins, input bit busy);
      @(negedge clk);
      rst             = r;
      bus.id_valid    = ins.v;
      bus.id_rs1      = REG_AW'(ins.rs1);
      bus.id_rs2      = REG_AW'(ins.rs2);
      bus.id_use_rs1  = ins.u1;
      bus.id_use_rs2  = ins.u2;
      bus.id_rd       = REG_AW'(ins.rd);
      bus.id_wr_en    = ins.wr;
      bus.id_is_load  = ins.ld;
      bus.id_redirect = ins.redir;
      bus.dmem_busy   = busy;
      #1;
      computeExpected(r, ins, busy);
      checkOutput("stall_if",  32'(bus.stall_if),  32'(eStallIf));
      checkOutput("stall_id",  32'(bus.stall_id),  32'(eStallId));
      checkOutput("stall_ex",  32'(bus.stall_ex),  32'(eStallEx));
      checkOutput("bubble_ex", 32'(bus.bubble_ex), 32'(eBubble));
      checkOutput("flush_if",  32'(bus.flush_if),  32'(eFlush));
      checkOutput("fwd_a",     32'(bus.fwd_a),     32'(eFwdA));
      checkOutput("fwd_b",     32'(bus.fwd_b),     32'(eFwdB));
      checkOutput("stall_cnt", bus.stall_cnt,      mStallCnt);
      @(posedge clk);
      modelStep(r, ins, busy);
   endtask

   // Present one instruction and keep it in ID until the pipeline accepts it.
   task automatic issueHeld(input instr_t ins);
      int n;
      n = 0;
      do begin
         applyStimulus(1'b1, ins, 1'b0);
         n++;
      end while (eStallId && n < 20);
   endtask

   function automatic instr_t randInstr();
      return mk($urandom_range(0, 7) != 0,
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                1'($urandom), 1'($urandom),
                int'($urandom_range(0, 4)),
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0);
   endfunction

   // Directed pipeline scenarios, then a randomized stream with ID held on stalls.
   initial begin
      instr_t nop, cur;
      bit     prevStall, r, busy;
      nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      modelReset();
      rst = 1'b0;
      bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0;
      bus.id_use_rs2 = 0; bus.id_rd = '0; bus.id_wr_en = 0; bus.id_is_load = 0;
      bus.id_redirect = 0; bus.dmem_busy = 0;
      @(posedge clk);
      applyStimulus(1'b0, nop, 1'b0);
      applyStimulus(1'b1, nop, 1'b0);

      $display("[TB] back-to-back forwarding");
      issueHeld(mk(1, 1, 2, 1, 1, 5, 1, 0, 0));
      issueHeld(mk(1, 5, 1, 1, 1, 6, 1, 0, 0));
      issueHeld(mk(1, 5, 0, 1, 1, 9, 1, 0, 0));

      $display("[TB] load-use");
      issueHeld(mk(1, 1, 0, 1, 0, 7, 1, 1, 0));
      issueHeld(mk(1, 7, 7, 1, 1, 8, 1, 0, 0));

      $display("[TB] x0 guard");
      issueHeld(mk(1, 1, 0, 1, 0, 0, 1, 1, 0));
      issueHeld(mk(1, 0, 0, 1, 1, 8, 1, 0, 0));

      $display("[TB] redirect in run and during load stall");
      issueHeld(mk(1, 1, 2, 1, 1, 3, 0, 0, 1));
      issueHeld(mk(1, 1, 0, 1, 0, 7, 1, 1, 0));
      issueHeld(mk(1, 7, 2, 1, 1, 0, 0, 0, 1));

      $display("[TB] memory busy during load stall");
      issueHeld(mk(1, 1, 0, 1, 0, 7, 1, 1, 0));
      cur = mk(1, 7, 1, 1, 1, 8, 1, 0, 0);
      applyStimulus(1'b1, cur, 1'b0);
      repeat (3) applyStimulus(1'b1, cur, 1'b1);
      issueHeld(cur);

      $display("[TB] reset during load stall");
      issueHeld(mk(1, 1, 0, 1, 0, 7, 1, 1, 0));
      applyStimulus(1'b1, mk(1, 7, 7, 1, 1, 8, 1, 0, 0), 1'b0);
      applyStimulus(1'b0, nop, 1'b0);
      applyStimulus(1'b1, nop, 1'b0);

      $display("[TB] random stream");
      prevStall = 0;
      cur = nop;
      for (int i = 0; i < RAND_CYCLES; i++) begin
         if (!prevStall) cur = randInstr();
         r    = ($urandom_range(0, 63) != 0);
         busy = ($urandom_range(0, 6) == 0);
         applyStimulus(r, cur, busy);
         prevStall = r && eStallId;
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
